// File: rtl/mod_n_seq_checker.sv
// Receive-side integrity checker for a wrapping mod-N counting stream.
// Locks onto 0..N-1, then flags and counts breaks and counts wraps.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   in_valid       qualifies in_data
//   in_data        received count value (WIDTH bits)
//   clear          synchronous clear of err_count and wrap_count
//   locked         high while in LOCKED state
//   err_pulse      one-cycle pulse on a sequence break while LOCKED
//   range_err      one-cycle pulse on a valid sample >= N
//   expected       next value the checker expects
//   err_count      saturating count of err_pulse events
//   wrap_count     saturating count of in-sequence N-1 samples while LOCKED
module mod_n_seq_checker #(
  parameter longint unsigned N          = 256,
  parameter int unsigned     WIDTH      = 32,
  parameter int unsigned     CNT_WIDTH  = 16,
  parameter int unsigned     LOCK_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 range_err,
  output logic [WIDTH-1:0]     expected,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] wrap_count
);

  // One extra bit so N == 2^WIDTH is representable.
  localparam logic [WIDTH:0] N_EXT = (WIDTH+1)'(N);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);
  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // With LOCK_COUNT == 1 the seed sample alone is enough to lock.
  localparam state_t SEED_ST = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;

  state_t               state_q, state_d;
  logic [MW-1:0]        match_q, match_d;
  logic [WIDTH-1:0]     exp_q, exp_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic                 rng_q, rng_d;
  logic [CNT_WIDTH-1:0] ecnt_q, ecnt_d;
  logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;

  logic             in_range;
  logic             hit;
  logic [WIDTH-1:0] nxt_in;
  logic             err_inc;
  logic             wrap_inc;

  assign in_range = {1'b0, in_data} < N_EXT;
  assign hit      = in_data == exp_q;
  assign nxt_in   = (in_data == LAST) ? '0 : in_data + WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    exp_d    = exp_q;
    err_d    = 1'b0;
    rng_d    = 1'b0;
    err_inc  = 1'b0;
    wrap_inc = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_range) begin
            exp_d   = nxt_in;
            match_d = MW'(1);
            state_d = SEED_ST;
          end else begin
            rng_d = 1'b1;
          end
        end
        ACQUIRE: begin
          if (!in_range) begin
            rng_d   = 1'b1;
            match_d = '0;
            state_d = HUNT;
          end else if (hit) begin
            exp_d   = nxt_in;
            match_d = match_q + MW'(1);
            if (match_q + MW'(1) == LOCK_M) begin
              state_d = LOCKED;
            end
          end else begin
            // Silent re-seed: errors only count once locked.
            exp_d   = nxt_in;
            match_d = MW'(1);
            state_d = SEED_ST;
          end
        end
        LOCKED: begin
          if (hit) begin
            exp_d    = nxt_in;
            wrap_inc = in_data == LAST;
          end else begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            if (in_range) begin
              exp_d   = nxt_in;
              match_d = MW'(1);
              state_d = SEED_ST;
            end else begin
              rng_d   = 1'b1;
              match_d = '0;
              state_d = HUNT;
            end
          end
        end
        default: begin
          match_d = '0;
          state_d = HUNT;
        end
      endcase
    end

    locked_d = state_d == LOCKED;

    // Clear has priority over a same-cycle increment.
    ecnt_d = ecnt_q;
    if (clear) begin
      ecnt_d = '0;
    end else if (err_inc && ecnt_q != CNT_MAX) begin
      ecnt_d = ecnt_q + CNT_WIDTH'(1);
    end

    wcnt_d = wcnt_q;
    if (clear) begin
      wcnt_d = '0;
    end else if (wrap_inc && wcnt_q != CNT_MAX) begin
      wcnt_d = wcnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      match_q  <= '0;
      exp_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      rng_q    <= 1'b0;
      ecnt_q   <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      exp_q    <= exp_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      rng_q    <= rng_d;
      ecnt_q   <= ecnt_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = err_q;
  assign range_err  = rng_q;
  assign expected   = exp_q;
  assign err_count  = ecnt_q;
  assign wrap_count = wcnt_q;

endmodule

// File: tb/tb_mod_n_seq_checker.sv
// Bench for mod_n_seq_checker: directed plan plus random stream,
// checked every cycle against a behavioural model.
module tb_mod_n_seq_checker;

  localparam int NN = 256;
  localparam int LC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        clear;

  logic        locked, err_pulse, range_err;
  logic [31:0] expected;
  logic [15:0] err_count, wrap_count;

  logic        locked_s, err_pulse_s, range_err_s;
  logic [31:0] expected_s;
  logic [1:0]  err_count_s, wrap_count_s;

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  always #5 clk = ~clk;

  mod_n_seq_checker #(
    .N(256), .WIDTH(32), .CNT_WIDTH(16), .LOCK_COUNT(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clear(clear), .locked(locked), .err_pulse(err_pulse),
    .range_err(range_err), .expected(expected),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  mod_n_seq_checker #(
    .N(256), .WIDTH(32), .CNT_WIDTH(2), .LOCK_COUNT(4)
  ) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clear(clear), .locked(locked_s), .err_pulse(err_pulse_s),
    .range_err(range_err_s), .expected(expected_s),
    .err_count(err_count_s), .wrap_count(wrap_count_s)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 hunt, 1 acquire, 2 locked.
  int          m_mode = 0;
  int          m_run  = 0;
  logic [31:0] m_exp  = 0;
  bit          m_err  = 0;
  bit          m_rng  = 0;
  int          m_ec   = 0;
  int          m_wc   = 0;

  function automatic int sat(input int v, input int cap);
    return (v > cap) ? cap : v;
  endfunction

  always @(posedge clk) begin
    int          md, run, ec, wc;
    logic [31:0] ex, nx;
    bit          e, r;
    md = m_mode; run = m_run; ex = m_exp; ec = m_ec; wc = m_wc;
    e = 0; r = 0;
    if (rst) begin
      md = 0; run = 0; ex = 0; ec = 0; wc = 0;
    end else begin
      if (in_valid) begin
        nx = (in_data == NN - 1) ? 0 : in_data + 1;
        if (md == 2 && in_data == ex) begin
          if (in_data == NN - 1) wc++;
          ex = nx;
        end else begin
          if (md == 2) begin
            e = 1;
            ec++;
          end
          if (in_data >= NN) begin
            r = 1; md = 0; run = 0;
          end else if (md == 1 && in_data == ex) begin
            run++;
            ex = nx;
            if (run == LC) md = 2;
          end else begin
            run = 1;
            ex = nx;
            md = (LC == 1) ? 2 : 1;
          end
        end
      end
      if (clear) begin
        ec = 0; wc = 0;
      end
    end
    m_mode <= md; m_run <= run; m_exp <= ex;
    m_err <= e; m_rng <= r; m_ec <= ec; m_wc <= wc;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("locked", locked, m_mode == 2);
      chk("err_pulse", err_pulse, m_err);
      chk("range_err", range_err, m_rng);
      chk("expected", expected, m_exp);
      chk("err_count", err_count, sat(m_ec, 65535));
      chk("wrap_count", wrap_count, sat(m_wc, 65535));
      chk("locked_s", locked_s, m_mode == 2);
      chk("err_count_s", err_count_s, sat(m_ec, 3));
      chk("wrap_count_s", wrap_count_s, sat(m_wc, 3));
    end
  end

  task automatic cyc(input bit v, input logic [31:0] d,
                     input bit c = 0);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(negedge clk);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    cyc(0, 0);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] b;
    rst = 1'b1; in_valid = 0; in_data = 0; clear = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    armed = 1;

    chk("rst_locked", locked, 0);
    chk("rst_expected", expected, 0);
    chk("rst_err_count", err_count, 0);

    // Acquire lock on 0..3.
    for (int i = 0; i < 3; i++) cyc(1, i);
    chk("pre_lock", locked, 0);
    cyc(1, 3);
    chk("lock_locked", locked, 1);
    chk("lock_expected", expected, 4);
    chk("lock_err_count", err_count, 0);

    // Run through the wrap.
    for (int i = 4; i < 256; i++) cyc(1, i);
    cyc(1, 0);
    cyc(1, 1);
    chk("wrap_count", wrap_count, 1);
    chk("wrap_expected", expected, 2);
    chk("wrap_locked", locked, 1);

    // Break at expected=10 with 50, then relock on 51..53.
    for (int i = 2; i < 10; i++) cyc(1, i);
    chk("pre_break_exp", expected, 10);
    cyc(1, 50);
    chk("break_pulse", err_pulse, 1);
    chk("break_err_count", err_count, 1);
    chk("break_locked", locked, 0);
    cyc(1, 51);
    chk("break_pulse_gone", err_pulse, 0);
    cyc(1, 52);
    cyc(1, 53);
    chk("relock_locked", locked, 1);
    chk("relock_expected", expected, 54);

    // Out-of-range sample while hunting.
    do_rst();
    cyc(1, 300);
    chk("range_pulse", range_err, 1);
    chk("range_locked", locked, 0);
    cyc(0, 0);
    chk("range_pulse_gone", range_err, 0);
    for (int i = 0; i < 4; i++) cyc(1, i);
    chk("range_relock", locked, 1);

    // Saturate the 2-bit error counter.
    for (int k = 0; k < 4; k++) begin
      b = (m_exp + 100) % NN;
      cyc(1, b);
      for (int j = 1; j < 4; j++) cyc(1, (b + j) % NN);
    end
    chk("sat_err_count_s", err_count_s, 3);
    chk("sat_err_count", err_count, 4);
    chk("sat_locked", locked, 1);
    b = (m_exp + 100) % NN;
    cyc(1, b, 1);
    chk("clr_pulse", err_pulse, 1);
    chk("clr_err_count", err_count, 0);
    chk("clr_err_count_s", err_count_s, 0);
    for (int j = 1; j < 4; j++) cyc(1, (b + j) % NN);

    // Idle gap keeps lock.
    for (int i = 0; i < 5; i++) cyc(0, 32'hDEAD_BEEF);
    chk("gap_locked", locked, 1);
    b = m_exp;
    cyc(1, b);
    chk("gap_locked2", locked, 1);
    chk("gap_no_err", err_pulse, 0);
    chk("gap_expected", expected, (b + 1) % NN);

    // Reset mid-stream.
    rst = 1'b1;
    cyc(1, m_exp);
    rst = 1'b0;
    chk("mrst_locked", locked, 0);
    chk("mrst_expected", expected, 0);
    chk("mrst_err_pulse", err_pulse, 0);
    chk("mrst_range_err", range_err, 0);
    chk("mrst_err_count", err_count, 0);
    chk("mrst_wrap_count", wrap_count, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      int k;
      bit v, c;
      logic [31:0] d;
      k = $urandom_range(99);
      if (k < 60) d = m_exp;
      else if (k < 85) d = $urandom_range(255);
      else if (k < 95) d = 256 + $urandom_range(1000);
      else if (k < 97) d = 32'hFFFF_FFFF;
      else d = $urandom;
      v = $urandom_range(99) < 85;
      c = $urandom_range(99) < 3;
      rst = $urandom_range(999) < 5;
      cyc(v, d, c);
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
